// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon Says sequence checker.
package simon_pkg;

  localparam int DEF_N_BTN     = 4;
  localparam int DEF_SEQ_DEPTH = 32;

  localparam logic FAIL_WRONG   = 1'b0;
  localparam logic FAIL_TIMEOUT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_WAIT_PRESS,
    ST_WAIT_RELEASE
  } state_e;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder; out-of-range indices decode to all zeros.
module onehot_dec #(
  parameter int  N = 4,
  localparam int W = simon_pkg::width_of(N)
) (
  input  logic [W-1:0] idx_i,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_i == W'(i)) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Walks one round of the stored Simon sequence and checks each player press.
// state        | meaning
// IDLE         | waiting for start; outputs from last round held
// FETCH        | mem_addr presented for current step
// LOAD         | memory data valid; latch expected index, arm timer
// WAIT_PRESS   | waiting for a fresh press edge, timer running
// WAIT_RELEASE | correct press seen; waiting for all switches released
module seq_checker
  import simon_pkg::*;
#(
  parameter int  N_BTN       = DEF_N_BTN,
  parameter int  SEQ_DEPTH   = DEF_SEQ_DEPTH,
  parameter int  TIMEOUT_CYC = 100_000_000,
  localparam int IDX_W       = width_of(N_BTN),
  localparam int ADDR_W      = width_of(SEQ_DEPTH),
  localparam int LEN_W       = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              on_off,
  input  logic              start,
  input  logic [LEN_W-1:0]  round_len,
  input  logic [N_BTN-1:0]  sw,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [IDX_W-1:0]  mem_data,
  output logic              busy,
  output logic              step_ok,
  output logic              round_done,
  output logic              fail,
  output logic              fail_cause,
  output logic [LEN_W-1:0]  progress
);

  localparam int CNT_W = width_of(TIMEOUT_CYC);

  state_e            state_q;
  logic [N_BTN-1:0]  sw_q;
  logic [IDX_W-1:0]  exp_q;
  logic [ADDR_W-1:0] idx_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_d;
  logic [CNT_W-1:0]  tmr_q;
  logic [N_BTN-1:0]  exp_oh;
  logic              press_edge;
  logic              press_ok;
  logic              last_step;

  onehot_dec #(.N(N_BTN)) u_exp_dec (
    .idx_i    (exp_q),
    .onehot_o (exp_oh)
  );

  assign press_edge = (sw != '0) && (sw_q == '0);
  assign press_ok   = (sw == exp_oh);
  assign last_step  = (({1'b0, idx_q} + LEN_W'(1)) == len_q);
  assign len_d      = (round_len > LEN_W'(SEQ_DEPTH)) ? LEN_W'(SEQ_DEPTH) : round_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sw_q       <= '0;
      exp_q      <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      tmr_q      <= '0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      step_ok    <= 1'b0;
      round_done <= 1'b0;
      fail       <= 1'b0;
      fail_cause <= FAIL_WRONG;
      progress   <= '0;
    end else begin
      sw_q       <= sw;
      step_ok    <= 1'b0;
      round_done <= 1'b0;
      fail       <= 1'b0;

      if (!on_off) begin
        state_q <= ST_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              len_q      <= len_d;
              idx_q      <= '0;
              progress   <= '0;
              fail_cause <= FAIL_WRONG;
              if (len_d == '0) begin
                round_done <= 1'b1;
              end else begin
                mem_addr <= '0;
                busy     <= 1'b1;
                state_q  <= ST_FETCH;
              end
            end
          end

          ST_FETCH: state_q <= ST_LOAD;

          ST_LOAD: begin
            exp_q   <= mem_data;
            tmr_q   <= CNT_W'(TIMEOUT_CYC - 1);
            state_q <= ST_WAIT_PRESS;
          end

          // A press edge takes priority over a timer expiring in the same cycle.
          ST_WAIT_PRESS: begin
            if (press_edge) begin
              if (press_ok) begin
                step_ok  <= 1'b1;
                progress <= progress + LEN_W'(1);
                if (last_step) begin
                  round_done <= 1'b1;
                  busy       <= 1'b0;
                  state_q    <= ST_IDLE;
                end else begin
                  idx_q   <= idx_q + ADDR_W'(1);
                  state_q <= ST_WAIT_RELEASE;
                end
              end else begin
                fail       <= 1'b1;
                fail_cause <= FAIL_WRONG;
                busy       <= 1'b0;
                state_q    <= ST_IDLE;
              end
            end else if (tmr_q == '0) begin
              fail       <= 1'b1;
              fail_cause <= FAIL_TIMEOUT;
              busy       <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              tmr_q <= tmr_q - CNT_W'(1);
            end
          end

          ST_WAIT_RELEASE: begin
            if (sw == '0) begin
              mem_addr <= idx_q;
              state_q  <= ST_FETCH;
            end
          end

          default: begin
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: directed rounds push expected events, a monitor checks pulses.
module tb_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       on_off = 1'b1;
  logic       start = 1'b0;
  logic [5:0] round_len = '0;
  logic [3:0] sw = '0;
  logic [4:0] mem_addr;
  logic [1:0] mem_data = '0;
  logic       busy, step_ok, round_done, fail, fail_cause;
  logic [5:0] progress;

  logic [1:0] mem [32];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic s;
    logic d;
    logic f;
    logic c;
    int   prog;
    int   at;
  } ev_t;

  ev_t exp_q[$];
  ev_t e;

  seq_checker #(.N_BTN(4), .SEQ_DEPTH(32), .TIMEOUT_CYC(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .on_off     (on_off),
    .start      (start),
    .round_len  (round_len),
    .sw         (sw),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (busy),
    .step_ok    (step_ok),
    .round_done (round_done),
    .fail       (fail),
    .fail_cause (fail_cause),
    .progress   (progress)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    mem_data <= mem[mem_addr];
  end

  // Monitor: flag events that never arrived, then match any pulse against the queue head.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_event: expected at cyc %0d step_ok=%b round_done=%b fail=%b, nothing seen",
               e.at, e.s, e.d, e.f);
    end
    if (!reset && (step_ok || round_done || fail)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event at cyc %0d: step_ok=%b round_done=%b fail=%b progress=%0d",
                 cyc, step_ok, round_done, fail, progress);
      end else begin
        e = exp_q.pop_front();
        if (step_ok !== e.s || round_done !== e.d || fail !== e.f ||
            (e.f && fail_cause !== e.c) || progress != 6'(e.prog) || cyc != e.at) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d so=%b rd=%b f=%b fc=%b prog=%0d, expected cyc=%0d so=%b rd=%b f=%b fc=%b prog=%0d",
                   cyc, step_ok, round_done, fail, fail_cause, progress,
                   e.at, e.s, e.d, e.f, e.c, e.prog);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic s, input logic d, input logic f, input logic c,
                           input int prog, input int at);
    ev_t x;
    x.s = s; x.d = d; x.f = f; x.c = c; x.prog = prog; x.at = at;
    exp_q.push_back(x);
  endtask

  task automatic do_start(input logic [5:0] len);
    start = 1'b1;
    round_len = len;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_step_ok", step_ok, 0);
    check("rst_round_done", round_done, 0);
    check("rst_fail", fail, 0);
    check("rst_fail_cause", fail_cause, 0);
    check("rst_progress", progress, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    tick(1);

    // Correct three-step round, with an ignored start while busy.
    mem[0] = 2; mem[1] = 0; mem[2] = 3;
    do_start(3);
    check("busy_after_start", busy, 1);
    check("mem_addr_step0", mem_addr, 0);
    tick(2);
    start = 1'b1; round_len = 6'd1; tick(1); start = 1'b0;
    check("start_while_busy", busy, 1);
    expect_ev(1, 0, 0, 0, 1, cyc + 1); sw = 4'b0100; tick(1); sw = '0; tick(3);
    check("mem_addr_step1", mem_addr, 1);
    expect_ev(1, 0, 0, 0, 2, cyc + 1); sw = 4'b0001; tick(1); sw = '0; tick(3);
    expect_ev(1, 1, 0, 0, 3, cyc + 1); sw = 4'b1000; tick(1);
    check("busy_after_done", busy, 0);
    check("progress_done", progress, 3);
    sw = '0; tick(2);

    // Wrong press on step two.
    mem[0] = 1; mem[1] = 1;
    do_start(2); tick(2);
    expect_ev(1, 0, 0, 0, 1, cyc + 1); sw = 4'b0010; tick(1); sw = '0; tick(3);
    expect_ev(0, 0, 1, 0, 1, cyc + 1); sw = 4'b0100; tick(1);
    check("busy_after_wrong", busy, 0);
    sw = '0; tick(3);
    check("fail_cause_wrong_held", fail_cause, 0);
    check("progress_wrong_held", progress, 1);

    // Timeout: fail ten cycles after entering WAIT_PRESS.
    mem[0] = 2;
    do_start(1); tick(2);
    expect_ev(0, 0, 1, 1, 0, cyc + 10);
    tick(12);
    check("fail_cause_timeout", fail_cause, 1);
    check("busy_after_timeout", busy, 0);

    // Press arriving on the timeout cycle wins.
    mem[0] = 3;
    do_start(1); tick(2); tick(9);
    expect_ev(1, 1, 0, 0, 1, cyc + 1); sw = 4'b1000; tick(1);
    sw = '0; tick(2);
    check("fail_cause_cleared", fail_cause, 0);

    // Multi-hot press is wrong.
    mem[0] = 1;
    do_start(1); tick(2);
    expect_ev(0, 0, 1, 0, 0, cyc + 1); sw = 4'b0110; tick(1);
    sw = '0; tick(2);

    // Button held before the step: needs release and fresh press.
    mem[0] = 0;
    sw = 4'b0001; tick(1);
    do_start(1); tick(2); tick(4);
    check("held_no_event", busy, 1);
    sw = '0; tick(1);
    expect_ev(1, 1, 0, 0, 1, cyc + 1); sw = 4'b0001; tick(1);
    sw = '0; tick(2);

    // Power dropped at step two.
    mem[0] = 2; mem[1] = 0; mem[2] = 3;
    do_start(3); tick(2);
    expect_ev(1, 0, 0, 0, 1, cyc + 1); sw = 4'b0100; tick(1); sw = '0; tick(3);
    on_off = 1'b0; tick(1);
    check("busy_power_off", busy, 0);
    check("progress_power_off", progress, 1);
    sw = 4'b0001; tick(3);
    sw = '0; on_off = 1'b1; tick(1);
    check("progress_power_held", progress, 1);

    // Zero-length round.
    expect_ev(0, 1, 0, 0, 0, cyc + 1);
    do_start(0);
    check("busy_len0", busy, 0);
    check("progress_len0", progress, 0);
    tick(2);

    // Length clipped to memory depth.
    for (int i = 0; i < 32; i++) mem[i] = 2'(i % 4);
    do_start(6'd40); tick(2);
    for (int i = 0; i < 32; i++) begin
      expect_ev(1, (i == 31), 0, 0, i + 1, cyc + 1);
      sw = 4'(1 << (i % 4));
      tick(1);
      sw = '0;
      if (i < 31) tick(3);
    end
    tick(2);
    check("progress_clip", progress, 32);
    check("busy_clip", busy, 0);

    // Asynchronous reset in WAIT_PRESS.
    mem[0] = 1; mem[1] = 2;
    do_start(2); tick(2);
    expect_ev(1, 0, 0, 0, 1, cyc + 1); sw = 4'b0010; tick(1); sw = '0; tick(3);
    check("busy_pre_reset", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_progress", progress, 0);
    check("async_mem_addr", mem_addr, 0);
    check("async_step_ok", step_ok, 0);
    tick(1);
    reset = 1'b0;
    tick(3);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
# seq_checker

Parametrised successor to the single-step compare block in the Simon Says datapath. Walks a whole round of the stored sequence, reading each expected button index from sequence memory and checking it against the player's switch presses. Detects press edges, enforces a per-step timeout, and reports per-step, round-complete and failure events to the game controller.

## Interface
Parameters:
- N_BTN, 4: number of buttons/switches; expected values are one-hot decoded to this width.
- SEQ_DEPTH, 32: sequence memory depth, i.e. maximum round length.
- TIMEOUT_CYC, 100_000_000: cycles allowed per press before timeout (must be >= 1).
- Derived (localparam): IDX_W = $clog2(N_BTN), ADDR_W = $clog2(SEQ_DEPTH), LEN_W = ADDR_W+1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- on_off  in  1  game power; low aborts any round synchronously and holds the block in IDLE.
- start  in  1  single-cycle pulse; begins a round (ignored unless IDLE).
- round_len  in  LEN_W  steps in the round; sampled on start.
- sw  in  N_BTN  switch vector from input block; already synchronous and debounced.
- mem_addr  out  ADDR_W  sequence memory read address.
- mem_data  in  IDX_W  expected button index; synchronous read, valid one cycle after mem_addr.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- step_ok  out  1  one-cycle pulse per correct press.
- round_done  out  1  one-cycle pulse when the last step is correct.
- fail  out  1  one-cycle pulse on wrong press or timeout.
- fail_cause  out  1  0 = wrong press, 1 = timeout; valid from the fail pulse until next accepted start.
- progress  out  LEN_W  correct steps so far this round; held after done/fail until next accepted start.

## Operation
- States: IDLE, FETCH, LOAD, WAIT_PRESS, WAIT_RELEASE.
- IDLE + start + on_off:
  - Latch len = min(round_len, SEQ_DEPTH).
  - Clear idx, progress and fail_cause.
  - len==0 → pulse round_done next cycle and stay IDLE. Otherwise → FETCH.
- FETCH: mem_addr = idx → LOAD.
- LOAD: latch expected = mem_data, clear timeout counter → WAIT_PRESS.
- Press edge: sw != 0 while the registered previous sw == 0.
- WAIT_PRESS with a press edge:
  - Correct means sw equals one-hot(expected) exactly. Multi-hot or wrong bit counts as wrong.
  - Correct, not last step: step_ok, progress+1, idx+1 → WAIT_RELEASE.
  - Correct, last step (idx==len-1): step_ok, round_done and progress+1 together → IDLE.
  - Wrong: fail with fail_cause=0 → IDLE.
- WAIT_PRESS with no edge: counter increments. Counter reaching TIMEOUT_CYC-1 → fail with fail_cause=1 → IDLE.
- WAIT_RELEASE: sw==0 → FETCH. No timeout in this state.
- Buttons already held when WAIT_PRESS is entered do not count. A fresh edge is required.
- on_off low in any state → IDLE next cycle with no pulses. progress and fail_cause are held.
- start while busy is ignored. mem_addr holds its last value in IDLE.

## Timing
- Reset values: mem_addr=0, busy=0, step_ok=0, round_done=0, fail=0, fail_cause=0, progress=0. State resets to IDLE and previous-sw register to 0.
- All outputs are registered.
- start sampled at cycle 0 → busy=1 and FETCH at cycle 1 → LOAD at 2 → WAIT_PRESS at 3.
- Press edge sampled at cycle t → pulse(s) visible at t+1.
- Release sampled at cycle r → FETCH at r+1 → WAIT_PRESS again at r+3.
- Press edge and timeout in the same cycle: the press wins.
- idx never wraps: len <= SEQ_DEPTH.

## Structure
- simon_pkg holds:
  - state enum;
  - fail_cause constants FAIL_WRONG/FAIL_TIMEOUT;
  - shared default N_BTN/SEQ_DEPTH.
- Sub-module onehot_dec #(N): generalised index → one-hot decoder, instantiated once for expected.

## Test plan
- len=3, mem={2,0,3}, N_BTN=4, correct presses 0100/0001/1000 with releases → three step_ok pulses, round_done with the third, progress=3, fail never high.
- len=2, mem={1,1}, press 0010, release, press 0100 → fail with fail_cause=0, progress=1, busy low the cycle after.
- TIMEOUT_CYC=10, no press after WAIT_PRESS → fail at exactly 10 cycles after WAIT_PRESS entry, fail_cause=1.
- Multi-hot press 0110 with expected 1 → fail, fail_cause=0. Button held from the previous step → no event until released and re-pressed.
- on_off dropped mid-round at step 2 → IDLE next cycle, no pulses. round_len=0 → round_done only. round_len=40 with SEQ_DEPTH=32 → 32 steps.
- reset asserted in WAIT_PRESS → all outputs 0 immediately (asynchronous). start during busy → ignored.
